// File: rtl/uart_frame_sched_pkg.sv
// Shared constants, state encoding and pacing math for the UART frame scheduler.
package uart_frame_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] CH0_ID   = 8'h00;
  localparam logic [7:0] CH1_ID   = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_LEN,
    ST_PAY,
    ST_CSUM
  } state_t;

  // Ten bits per byte plus one bit of slack, so uart_send is idle before the next launch.
  function automatic int byte_cycles(input int clkFreq, input int bps);
    return (clkFreq / bps) * 11;
  endfunction

endpackage

// File: rtl/uart_frame_sched_if.sv
// Bundle between the two frame sources, the scheduler and the uart_send byte transmitter.
interface uart_frame_sched_if;
  logic [1:0] req;
  logic [7:0] len0;
  logic [7:0] len1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic [1:0] gnt;
  logic [1:0] rd;
  logic [1:0] done;
  logic       busy;
  logic       tx_en;
  logic [7:0] tx_data;

  modport master (
    output req, len0, len1, rdata0, rdata1,
    input  gnt, rd, done, busy, tx_en, tx_data
  );

  modport slave (
    input  req, len0, len1, rdata0, rdata1,
    output gnt, rd, done, busy, tx_en, tx_data
  );
endinterface

// File: rtl/uart_frame_sched_gap_timer.sv
// Byte-slot timer: restarted by each launch, pulses expired on the last cycle of the slot.
module uart_gap_timer #(
  parameter int CYCLES = 110
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Loading CYCLES-1 and firing at 1 lets the next launch register exactly CYCLES after this one.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = W'(CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/uart_frame_sched.sv
// Two-channel round-robin frame scheduler feeding uart_send: SOF, ID, LEN, payload, checksum.
module uart_frame_sched
  import uart_frame_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 128000
) (
  input logic               sys_clk,
  input logic               sys_rst,
  uart_frame_sched_if.slave bus
);

  // Must come out at 3 or more for the payload prefetch to land in time.
  localparam int BYTE_CYCLES = byte_cycles(CLK_FREQ, UART_BPS);

  state_t     state_q;
  logic       sofPend_q;
  logic       ch_q;
  logic       prio_q;
  logic [7:0] len_q;
  logic [7:0] remain_q;
  logic [7:0] csum_q;
  logic [7:0] pay_q;
  logic       rdLate_q;
  logic [1:0] gnt_q;
  logic [1:0] rd_q;
  logic [1:0] done_q;
  logic       busy_q;
  logic       txEn_q;
  logic [7:0] txData_q;

  logic       gapExpired;
  logic       grantCh;
  logic [7:0] rdataSel;
  logic [7:0] payByte;
  logic [7:0] chanId;
  logic       rdNeed;

  uart_gap_timer #(.CYCLES(BYTE_CYCLES)) u_gap (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .start   (txEn_q),
    .expired (gapExpired)
  );

  assign grantCh  = (bus.req == 2'b11) ? prio_q : bus.req[1];
  assign rdataSel = ch_q ? bus.rdata1 : bus.rdata0;
  assign payByte  = rdLate_q ? rdataSel : pay_q;
  assign chanId   = ch_q ? CH1_ID : CH0_ID;
  assign rdNeed   = txEn_q && (((state_q == ST_LEN) && (len_q != 8'd0)) ||
                               ((state_q == ST_PAY) && (remain_q != 8'd0)));

  // Each expiry launches the next state's byte on the same edge, keeping launches one slot apart.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      sofPend_q <= 1'b0;
      ch_q      <= 1'b0;
      prio_q    <= 1'b0;
      len_q     <= 8'd0;
      remain_q  <= 8'd0;
      csum_q    <= 8'd0;
      pay_q     <= 8'd0;
      rdLate_q  <= 1'b0;
      gnt_q     <= 2'b00;
      rd_q      <= 2'b00;
      done_q    <= 2'b00;
      busy_q    <= 1'b0;
      txEn_q    <= 1'b0;
      txData_q  <= 8'd0;
    end else begin
      gnt_q    <= 2'b00;
      rd_q     <= 2'b00;
      done_q   <= 2'b00;
      txEn_q   <= 1'b0;
      rdLate_q <= |rd_q;
      if (rdLate_q) begin
        pay_q <= rdataSel;
      end
      if (rdNeed) begin
        rd_q <= ch_q ? 2'b10 : 2'b01;
      end

      case (state_q)
        ST_IDLE: begin
          if (|bus.req) begin
            gnt_q     <= grantCh ? 2'b10 : 2'b01;
            ch_q      <= grantCh;
            prio_q    <= ~grantCh;
            len_q     <= grantCh ? bus.len1 : bus.len0;
            csum_q    <= 8'd0;
            busy_q    <= 1'b1;
            sofPend_q <= 1'b1;
            state_q   <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (sofPend_q) begin
            sofPend_q <= 1'b0;
            txEn_q    <= 1'b1;
            txData_q  <= SOF_BYTE;
          end else if (gapExpired) begin
            txEn_q   <= 1'b1;
            txData_q <= chanId;
            csum_q   <= csum_q + chanId;
            state_q  <= ST_ID;
          end
        end
        ST_ID: begin
          if (gapExpired) begin
            txEn_q   <= 1'b1;
            txData_q <= len_q;
            csum_q   <= csum_q + len_q;
            state_q  <= ST_LEN;
          end
        end
        ST_LEN, ST_PAY: begin
          if (gapExpired) begin
            txEn_q <= 1'b1;
            if (((state_q == ST_LEN) && (len_q == 8'd0)) ||
                ((state_q == ST_PAY) && (remain_q == 8'd0))) begin
              txData_q <= csum_q;
              state_q  <= ST_CSUM;
            end else begin
              txData_q <= payByte;
              csum_q   <= csum_q + payByte;
              remain_q <= (state_q == ST_LEN) ? (len_q - 8'd1) : (remain_q - 8'd1);
              state_q  <= ST_PAY;
            end
          end
        end
        ST_CSUM: begin
          if (gapExpired) begin
            done_q  <= ch_q ? 2'b10 : 2'b01;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rd      = rd_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.tx_en   = txEn_q;
  assign bus.tx_data = txData_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Self-checking bench for uart_frame_sched: frame contents, pacing, arbitration and reset recovery.
`timescale 1ns/1ps
module tb_uart_frame_sched;

  localparam int BC = 110;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  uart_frame_sched_if bus();

  uart_frame_sched #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] txBytes[$];
  int         txCycles[$];
  int         gntCyc[$];
  int         gntCh[$];
  int         doneCyc[$];
  int         doneCh[$];
  int         rdCnt[2];
  int         stabErr, ohErr, busyErr;
  logic [7:0] lastData;
  logic       busyExp;
  logic [7:0] payQ0[$];
  logic [7:0] payQ1[$];
  logic [7:0] curPay[$];
  logic [7:0] expQ[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Observer and payload source: records launches, grants, pulls and completions mid-cycle.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      bus.rdata0 = 8'h00;
      bus.rdata1 = 8'h00;
      lastData   = 8'h00;
      busyExp    = 1'b0;
    end else begin
      if (bus.tx_en) begin
        txBytes.push_back(bus.tx_data);
        txCycles.push_back(cyc);
      end else if (bus.tx_data !== lastData) begin
        stabErr++;
      end
      lastData = bus.tx_data;
      if (bus.gnt != 2'b00) begin
        gntCyc.push_back(cyc);
        gntCh.push_back(bus.gnt[1] ? 1 : 0);
        busyExp = 1'b1;
        if (bus.gnt == 2'b11) ohErr++;
      end
      if (bus.done != 2'b00) begin
        doneCyc.push_back(cyc);
        doneCh.push_back(bus.done[1] ? 1 : 0);
        busyExp = 1'b0;
        if (bus.done == 2'b11) ohErr++;
      end
      if (bus.busy !== busyExp) busyErr++;
      if (bus.rd == 2'b11) ohErr++;
      if (bus.rd[0]) begin
        rdCnt[0]++;
        bus.rdata0 = (payQ0.size() > 0) ? payQ0.pop_front() : 8'h00;
      end
      if (bus.rd[1]) begin
        rdCnt[1]++;
        bus.rdata1 = (payQ1.size() > 0) ? payQ1.pop_front() : 8'h00;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_records();
    txBytes.delete(); txCycles.delete();
    gntCyc.delete(); gntCh.delete();
    doneCyc.delete(); doneCh.delete();
    rdCnt[0] = 0; rdCnt[1] = 0;
    stabErr = 0; ohErr = 0; busyErr = 0;
    expQ.delete();
  endtask

  // Reference frame: SOF, id, length, payload, then the mod-256 sum of everything after SOF.
  task automatic add_expected(input int ch);
    int sum;
    sum = ch + curPay.size();
    expQ.push_back(8'hA5);
    expQ.push_back(8'(ch));
    expQ.push_back(8'(curPay.size()));
    foreach (curPay[i]) begin
      expQ.push_back(curPay[i]);
      sum += int'(curPay[i]);
    end
    expQ.push_back(8'(sum % 256));
  endtask

  function automatic string fmt_bytes(input bit useExp);
    string s;
    int    n;
    s = "";
    n = useExp ? expQ.size() : txBytes.size();
    for (int i = 0; i < n && i < 40; i++)
      s = {s, $sformatf("%02h ", useExp ? expQ[i] : txBytes[i])};
    return s;
  endfunction

  task automatic wait_gnt(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk); #1;
      if (gntCyc.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk); #1;
      if (doneCyc.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    sys_rst = 1'b1;
    bus.req = 2'b00; bus.len0 = 8'h00; bus.len1 = 8'h00;
    repeat (3) @(negedge sys_clk);
    outs = {bus.gnt, bus.rd, bus.done, bus.busy, bus.tx_en, bus.tx_data};
    vectors++;
    if (outs !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, required 0000", outs);
    end
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    outs = {bus.gnt, bus.rd, bus.done, bus.busy, bus.tx_en, bus.tx_data};
    vectors++;
    if (outs !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL idle_no_req: got %h, required 0000", outs);
    end
  endtask

  // Single frames: three directed cases from the plan, then randomized channel/length/payload.
  task automatic test_single_frames();
    int ch, len, reqCyc, badSp, nBad;
    bit ok, okDone;
    for (int t = 0; t < 9; t++) begin
      clear_records();
      curPay.delete();
      case (t)
        0: begin ch = 0; curPay.push_back(8'h10); curPay.push_back(8'h20); end
        1: begin ch = 1; end
        2: begin ch = 1; repeat (3) curPay.push_back(8'hFF); end
        default: begin
          ch  = $urandom_range(0, 1);
          len = $urandom_range(0, 6);
          for (int i = 0; i < len; i++) curPay.push_back(8'($urandom_range(0, 255)));
        end
      endcase
      len = curPay.size();
      foreach (curPay[i]) begin
        if (ch == 0) payQ0.push_back(curPay[i]); else payQ1.push_back(curPay[i]);
      end
      add_expected(ch);

      @(negedge sys_clk);
      bus.len0 = (ch == 0) ? 8'(len) : 8'($urandom_range(0, 255));
      bus.len1 = (ch == 1) ? 8'(len) : 8'($urandom_range(0, 255));
      bus.req  = (ch == 0) ? 2'b01 : 2'b10;
      reqCyc   = cyc;
      wait_gnt(1, 10, ok);
      bus.req  = 2'b00;
      bus.len0 = 8'($urandom_range(0, 255));
      bus.len1 = 8'($urandom_range(0, 255));
      wait_done(1, (len + 6) * BC, okDone);
      repeat (3) @(negedge sys_clk);
      payQ0.delete(); payQ1.delete();

      vectors++;
      if (!ok || !okDone) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_timeout: gnt seen %0d done seen %0d, required 1 1", t, ok, okDone);
      end
      nBad = 0;
      foreach (expQ[i]) if (i >= txBytes.size() || txBytes[i] !== expQ[i]) nBad++;
      vectors++;
      if (nBad != 0 || txBytes.size() != expQ.size()) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_bytes: got %s required %s", t, fmt_bytes(0), fmt_bytes(1));
      end
      vectors++;
      if (gntCyc.size() != 1 || gntCh[0] != ch || gntCyc[0] != reqCyc + 1) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_grant: count %0d ch %0d latency %0d, required 1 %0d 1",
                 t, gntCyc.size(), gntCh[0], gntCyc[0] - reqCyc, ch);
      end
      vectors++;
      if (txCycles.size() == 0 || gntCyc.size() == 0 || txCycles[0] != gntCyc[0] + 1) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_sof_latency: got %0d, required 1", t, txCycles[0] - gntCyc[0]);
      end
      vectors++;
      if (rdCnt[ch] != len || rdCnt[1 - ch] != 0) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_rd_count: got ch%0d=%0d other=%0d, required %0d 0",
                 t, ch, rdCnt[ch], rdCnt[1 - ch], len);
      end
      vectors++;
      if (doneCyc.size() != 1 || doneCh[0] != ch || txCycles.size() == 0 ||
          doneCyc[0] - txCycles[0] != (len + 4) * BC) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_done: count %0d ch %0d after_sof %0d, required 1 %0d %0d",
                 t, doneCyc.size(), doneCh[0], doneCyc[0] - txCycles[0], ch, (len + 4) * BC);
      end
      badSp = 0;
      for (int i = 1; i < txCycles.size(); i++) if (txCycles[i] - txCycles[i - 1] != BC) badSp++;
      vectors++;
      if (badSp != 0 || stabErr != 0 || ohErr != 0 || busyErr != 0) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_pacing: bad_spacing %0d unstable %0d onehot %0d busy %0d, required 0 0 0 0",
                 t, badSp, stabErr, ohErr, busyErr);
      end
    end
  endtask

  // Both requests held high from reset: frames must alternate ch0, ch1, ch0 with one idle cycle between.
  task automatic test_back_to_back();
    logic [7:0] a, b, c, d;
    int badSp, nBad, idx, want;
    int flen[3];
    bit ok;
    sys_rst = 1'b1;
    bus.req = 2'b00;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    clear_records();
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255)); d = 8'($urandom_range(0, 255));
    payQ0.push_back(a); payQ0.push_back(b);
    payQ1.push_back(c); payQ1.push_back(d);
    curPay.delete(); curPay.push_back(a); add_expected(0);
    curPay.delete(); curPay.push_back(c); curPay.push_back(d); add_expected(1);
    curPay.delete(); curPay.push_back(b); add_expected(0);
    flen[0] = 5; flen[1] = 6; flen[2] = 5;
    bus.len0 = 8'd1; bus.len1 = 8'd2;
    bus.req  = 2'b11;
    wait_done(3, 25 * BC, ok);
    bus.req  = 2'b00;
    repeat (3) @(negedge sys_clk);
    payQ0.delete(); payQ1.delete();

    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL b2b_timeout: done count %0d, required 3", doneCyc.size());
    end
    nBad = 0;
    foreach (expQ[i]) if (i >= txBytes.size() || txBytes[i] !== expQ[i]) nBad++;
    vectors++;
    if (nBad != 0 || txBytes.size() != expQ.size()) begin
      miscompares++;
      $display("[TB] FAIL b2b_bytes: got %s required %s", fmt_bytes(0), fmt_bytes(1));
    end
    vectors++;
    if (gntCh.size() != 3 || gntCh[0] != 0 || gntCh[1] != 1 || gntCh[2] != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_order: got %0d grants %0d %0d %0d, required 3 grants 0 1 0",
               gntCh.size(), gntCh[0], gntCh[1], gntCh[2]);
    end
    vectors++;
    if (doneCyc.size() < 3 || gntCyc.size() < 3 ||
        gntCyc[1] != doneCyc[0] + 1 || gntCyc[2] != doneCyc[1] + 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap: grant-after-done %0d %0d, required 1 1",
               gntCyc[1] - doneCyc[0], gntCyc[2] - doneCyc[1]);
    end
    vectors++;
    if (rdCnt[0] != 2 || rdCnt[1] != 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_rd_count: got %0d %0d, required 2 2", rdCnt[0], rdCnt[1]);
    end
    badSp = 0;
    idx = 0;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < flen[f]; j++) begin
        if (idx > 0 && idx < txCycles.size()) begin
          want = (j == 0) ? BC + 2 : BC;
          if (txCycles[idx] - txCycles[idx - 1] != want) badSp++;
        end
        idx++;
      end
    end
    vectors++;
    if (badSp != 0 || stabErr != 0 || ohErr != 0 || busyErr != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_pacing: bad_spacing %0d unstable %0d onehot %0d busy %0d, required 0 0 0 0",
               badSp, stabErr, ohErr, busyErr);
    end
  endtask

  // Reset during the second payload byte, then a fresh frame must come out clean.
  task automatic test_reset_midframe();
    logic [15:0] outs;
    int nBad, len;
    bit ok, okTx, okDone;
    clear_records();
    curPay.delete();
    repeat (3) payQ0.push_back(8'($urandom_range(0, 255)));
    @(negedge sys_clk);
    bus.len0 = 8'd3;
    bus.req  = 2'b01;
    wait_gnt(1, 10, ok);
    bus.req  = 2'b00;
    okTx = 1'b0;
    for (int i = 0; i < 6 * BC; i++) begin
      @(negedge sys_clk); #1;
      if (txBytes.size() >= 5) begin okTx = 1'b1; break; end
    end
    repeat (20) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    outs = {bus.gnt, bus.rd, bus.done, bus.busy, bus.tx_en, bus.tx_data};
    vectors++;
    if (!ok || !okTx || outs !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %h reached_pay2 %0d, required 0000 1", outs, okTx);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    payQ0.delete();
    @(negedge sys_clk);
    clear_records();
    curPay.delete();
    len = 2;
    for (int i = 0; i < len; i++) curPay.push_back(8'($urandom_range(0, 255)));
    foreach (curPay[i]) payQ0.push_back(curPay[i]);
    add_expected(0);
    bus.len0 = 8'(len);
    bus.req  = 2'b01;
    wait_gnt(1, 10, ok);
    bus.req  = 2'b00;
    wait_done(1, (len + 6) * BC, okDone);
    repeat (3) @(negedge sys_clk);
    nBad = 0;
    foreach (expQ[i]) if (i >= txBytes.size() || txBytes[i] !== expQ[i]) nBad++;
    vectors++;
    if (!ok || !okDone || nBad != 0 || txBytes.size() != expQ.size()) begin
      miscompares++;
      $display("[TB] FAIL midreset_recover: got %s required %s", fmt_bytes(0), fmt_bytes(1));
    end
    vectors++;
    if (rdCnt[0] != len || doneCyc.size() != 1 || txCycles.size() == 0 ||
        doneCyc[0] - txCycles[0] != (len + 4) * BC || stabErr != 0 || busyErr != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_timing: rd %0d done %0d after_sof %0d unstable %0d busy %0d, required %0d 1 %0d 0 0",
               rdCnt[0], doneCyc.size(), doneCyc[0] - txCycles[0], stabErr, busyErr, len, (len + 4) * BC);
    end
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.len0 = 8'h00;
    bus.len1 = 8'h00;
    clear_records();
    test_reset();
    test_single_frames();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
